// File: rtl/x_counter_8_bit_checker.sv
// Receive-side checker for an 8-bit free-running counter: locks onto the incrementing
// sequence, flags non-increments and keeps a saturating error tally.
// Optional build macro X_COUNTER_8_BIT_CHECKER_RESYNC_EN re-aligns the expected value on a mismatch.
module x_counter_8_bit_checker #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned MISS_MAX = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_count_7,
    input  logic i_count_6,
    input  logic i_count_5,
    input  logic i_count_4,
    input  logic i_count_3,
    input  logic i_count_2,
    input  logic i_count_1,
    input  logic i_count_0,
    output logic o_locked,
    output logic o_error,
    output logic o_err_count_3,
    output logic o_err_count_2,
    output logic o_err_count_1,
    output logic o_err_count_0
);

    localparam logic [3:0] LOCK_CNT_C = 4'(LOCK_CNT);
    localparam logic [3:0] MISS_MAX_C = 4'(MISS_MAX);

    typedef enum logic [1:0] {
        ST_PRIME  = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  exp_q, exp_d;
    logic [3:0]  good_q, good_d;
    logic [3:0]  miss_q, miss_d;
    logic [3:0]  err_cnt_q, err_cnt_d;
    logic        locked_q, locked_d;
    logic        error_q, error_d;
    logic        match_s;

    function automatic logic [3:0] sat_inc4(input logic [3:0] val);
        if (val == 4'hF) begin
            sat_inc4 = 4'hF;
        end else begin
            sat_inc4 = val + 4'd1;
        end
    endfunction

    assign match_s = (rx_q == exp_q);

    // State and pipeline registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_PRIME;
            rx_q      <= 8'd0;
            exp_q     <= 8'd0;
            good_q    <= 4'd0;
            miss_q    <= 4'd0;
            err_cnt_q <= 4'd0;
            locked_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_q      <= rx_d;
            exp_q     <= exp_d;
            good_q    <= good_d;
            miss_q    <= miss_d;
            err_cnt_q <= err_cnt_d;
            locked_q  <= locked_d;
            error_q   <= error_d;
        end
    end

    // Next-state logic for the lock FSM, counters and output pulses.
    always_comb begin
        state_d   = state_q;
        rx_d      = {i_count_7, i_count_6, i_count_5, i_count_4,
                     i_count_3, i_count_2, i_count_1, i_count_0};
        exp_d     = exp_q;
        good_d    = good_q;
        miss_d    = miss_q;
        err_cnt_d = err_cnt_q;
        locked_d  = (state_q == ST_LOCKED);
        error_d   = 1'b0;

        case (state_q)
            ST_PRIME: begin
                // rx_q still holds its reset value here, so no comparison is made.
                exp_d   = rx_q + 8'd1;
                state_d = ST_SEARCH;
            end
            ST_SEARCH: begin
                exp_d = rx_q + 8'd1;
                if (match_s) begin
                    if ((good_q + 4'd1) == LOCK_CNT_C) begin
                        good_d  = 4'd0;
                        state_d = ST_LOCKED;
                    end else begin
                        good_d = good_q + 4'd1;
                    end
                end else begin
                    good_d = 4'd0;
                end
            end
            ST_LOCKED: begin
                if (match_s) begin
                    miss_d = 4'd0;
                    exp_d  = exp_q + 8'd1;
                end else begin
                    error_d   = 1'b1;
                    err_cnt_d = sat_inc4(err_cnt_q);
`ifdef X_COUNTER_8_BIT_CHECKER_RESYNC_EN
                    exp_d = rx_q + 8'd1;
`else
                    exp_d = exp_q + 8'd1;
`endif
                    if ((miss_q + 4'd1) == MISS_MAX_C) begin
                        miss_d  = 4'd0;
                        state_d = ST_SEARCH;
                    end else begin
                        miss_d = miss_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_PRIME;
                good_d  = 4'd0;
                miss_d  = 4'd0;
            end
        endcase
    end

    assign o_locked      = locked_q;
    assign o_error       = error_q;
    assign o_err_count_3 = err_cnt_q[3];
    assign o_err_count_2 = err_cnt_q[2];
    assign o_err_count_1 = err_cnt_q[1];
    assign o_err_count_0 = err_cnt_q[0];

endmodule
